// File: rtl/mc_mem.sv
// mc_mem: multi-cycle, byte-addressable memory with a request/busy/done
// handshake, a fixed access latency and per-byte write enables.
// Only one request is outstanding at a time, so pipeline stages can model
// stalls on memory latency.
//
// Optional feature macro: MC_MEM_ALIGN_CHECK_EN
//   defined   - a request with nonzero addr[OFS-1:0] is rejected. It never
//               enters ACCESS, and err and done pulse together one cycle
//               after the accept edge.
//   undefined - err is tied 0 and the low address bits are ignored.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous reset, active low
//   req      in   request strobe, accepted when busy is low
//   wr       in   1 = write, 0 = read (sampled with req)
//   addr     in   byte address; low OFS bits select a byte within the word
//   data_in  in   write data
//   be       in   byte enables; be[i] covers data_in[8i+7:8i]
//   busy     out  access in progress; new requests are ignored
//   done     out  one-cycle completion pulse
//   data_out out  registered read data, held until the next read completes
//   err      out  misaligned-access pulse (only with the macro defined)

module mc_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    wr,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    err
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int OFS       = $clog2(NUM_BYTES);
    localparam int WADDR_W   = ADDR_WIDTH - OFS;
    localparam int DEPTH     = 2 ** WADDR_W;
    localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic                 accept;
    logic                 complete;
    logic                 misaligned;

    logic                 wr_q;
    logic [WADDR_W-1:0]   waddr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [NUM_BYTES-1:0] be_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef MC_MEM_ALIGN_CHECK_EN
    logic align_pend;

    assign misaligned = (addr[OFS-1:0] != '0);
`else
    logic unused_addr_lsbs;

    // Without the check, the byte offset is meaningless: the access goes to
    // the containing word.
    assign unused_addr_lsbs = ^addr[OFS-1:0];
    assign misaligned       = 1'b0;
    assign err              = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake decode. The access completes on the edge at
    // which the counter has already reached zero. That edge is the LATENCY-th
    // edge after the one that loaded LATENCY-1.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (!misaligned) begin
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counter, done pulse and read-data register. Reset aborts any pending
    // access, so no done pulse can escape a reset edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
`ifdef MC_MEM_ALIGN_CHECK_EN
            done <= complete | align_pend;
`else
            done <= complete;
`endif
            if (accept) begin
                cnt <= CNT_LOAD;
            end else if (busy && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (complete && !wr_q) begin
                data_out <= mem[waddr_q];
            end
        end
    end

`ifdef MC_MEM_ALIGN_CHECK_EN
    // A rejected request reports back one cycle after the accept edge. This
    // matches the timing of a LATENCY=1 access, so requesters see a uniform
    // minimum latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            align_pend <= 1'b0;
            err        <= 1'b0;
        end else begin
            align_pend <= accept & misaligned;
            err        <= align_pend;
        end
    end
`endif

    // Request capture. The requester may change its inputs right after the
    // accept edge, so everything the access needs is latched here.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= wr;
            waddr_q <= addr[ADDR_WIDTH-1:OFS];
            data_q  <= data_in;
            be_q    <= be;
        end
    end

    // Storage. The array is deliberately not reset. Writes are gated by rst
    // so that a reset on the completion edge aborts the write.
    always_ff @(posedge clk) begin
        if (rst && complete && wr_q) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (be_q[i]) begin
                    mem[waddr_q][8*i +: 8] <= data_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mc_mem.sv
// tb_mc_mem: directed plus randomized bench for mc_mem (16-bit words,
// 16-bit byte addresses, LATENCY=4). The expected memory contents live in a
// word-indexed associative array updated with byte-merge arithmetic. Expected
// timing is stated directly: done arrives LATENCY edges after the accept edge.
// The bench follows MC_MEM_ALIGN_CHECK_EN when it is defined for both files.

module tb_mc_mem;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int LAT = 4;

    logic          clk;
    logic          rst;
    logic          req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [1:0]    be;
    logic          busy;
    logic          done;
    logic [DW-1:0] data_out;
    logic          err;

    int vectors;
    int miscompares;

    logic [DW-1:0] model [logic [AW-2:0]];
    logic [DW-1:0] lastRead;

    mc_mem #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LATENCY   (LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr      (wr),
        .addr    (addr),
        .data_in (data_in),
        .be      (be),
        .busy    (busy),
        .done    (done),
        .data_out(data_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] old,
                                                 input logic [DW-1:0] nw,
                                                 input logic [1:0]    b);
        logic [DW-1:0] r;
        r = old;
        if (b[0]) r[7:0]  = nw[7:0];
        if (b[1]) r[15:8] = nw[15:8];
        return r;
    endfunction

    function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] a);
        if (model.exists(a[AW-1:1])) return model[a[AW-1:1]];
        return 'x;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One complete access. The request is presented now, and the task returns
    // in the cycle where done is high. A following call therefore exercises
    // back-to-back acceptance.
    task automatic applyStimulus(input logic w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [1:0] b,
                                 input string tag);
        int   n;
        logic busyOk;
        req = 1'b1; wr = w; addr = a; data_in = d; be = b;
        tick;
        req = 1'b0;
`ifdef MC_MEM_ALIGN_CHECK_EN
        if (a[0]) begin
            checkOutput({tag, "_al_busy0"}, busy, 1'b0);
            checkOutput({tag, "_al_done0"}, done, 1'b0);
            tick;
            checkOutput({tag, "_al_done"}, done, 1'b1);
            checkOutput({tag, "_al_err"}, err, 1'b1);
            checkOutput({tag, "_al_busy1"}, busy, 1'b0);
            checkOutput({tag, "_al_dout"}, data_out, lastRead);
            return;
        end
`endif
        n      = 0;
        busyOk = 1'b1;
        while (!done && n < LAT + 8) begin
            if (!busy) busyOk = 1'b0;
            tick;
            n++;
        end
        checkOutput({tag, "_latency"}, n, LAT);
        checkOutput({tag, "_busy_held"}, busyOk, 1'b1);
        checkOutput({tag, "_busy_end"}, busy, 1'b0);
        checkOutput({tag, "_err"}, err, 1'b0);
        if (w) begin
            model[a[AW-1:1]] = mergeBytes(modelRead(a), d, b);
        end else begin
            lastRead = modelRead(a);
        end
        checkOutput({tag, "_dout"}, data_out, lastRead);
    endtask

    initial begin
        int doneCount;
        logic [DW-1:0] seen;
        vectors     = 0;
        miscompares = 0;
        lastRead    = '0;
        rst = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; data_in = '0; be = '0;

        $display("[TB] reset with random request activity");
        for (int i = 0; i < 2; i++) begin
            req = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
            addr = 16'($urandom); data_in = 16'($urandom); be = 2'($urandom);
            tick;
            checkOutput("reset_done", done, 1'b0);
            checkOutput("reset_err", err, 1'b0);
            checkOutput("reset_busy", busy, 1'b0);
        end
        req = 1'b0;
        checkOutput("reset_dout", data_out, 16'h0000);
        rst = 1'b1;
        tick;

        $display("[TB] write then read");
        applyStimulus(1'b1, 16'h0010, 16'hBEEF, 2'b11, "wr_beef");
        applyStimulus(1'b0, 16'h0010, 16'h0000, 2'b00, "rd_beef");
        checkOutput("rd_beef_const", data_out, 16'hBEEF);
        for (int i = 0; i < 3; i++) begin
            tick;
            checkOutput("hold_done", done, 1'b0);
            checkOutput("hold_dout", data_out, 16'hBEEF);
        end

        $display("[TB] byte enables");
        applyStimulus(1'b1, 16'h0020, 16'h1234, 2'b11, "be_full");
        applyStimulus(1'b1, 16'h0020, 16'hABCD, 2'b01, "be_low");
        applyStimulus(1'b0, 16'h0020, 16'h0000, 2'b10, "be_rd1");
        checkOutput("be_rd1_const", data_out, 16'h12CD);
        applyStimulus(1'b1, 16'h0020, 16'hFFFF, 2'b00, "be_none");
        applyStimulus(1'b0, 16'h0020, 16'h0000, 2'b11, "be_rd2");
        checkOutput("be_rd2_const", data_out, 16'h12CD);

        $display("[TB] request while busy");
        applyStimulus(1'b1, 16'h0030, 16'h0123, 2'b11, "pre_30");
        req = 1'b1; wr = 1'b0; addr = 16'h0010; be = 2'b11;
        tick;
        req = 1'b0;
        tick;
        req = 1'b1; wr = 1'b1; addr = 16'h0030; data_in = 16'h5555; be = 2'b11;
        tick;
        req = 1'b0;
        doneCount = 0;
        seen      = '0;
        for (int i = 0; i < LAT + 4; i++) begin
            if (done) begin
                doneCount++;
                seen = data_out;
            end
            tick;
        end
        checkOutput("busy_req_dones", doneCount, 1);
        checkOutput("busy_req_data", seen, 16'hBEEF);
        lastRead = 16'hBEEF;
        applyStimulus(1'b0, 16'h0030, 16'h0000, 2'b11, "rd_30");
        checkOutput("rd_30_const", data_out, 16'h0123);

        $display("[TB] reset mid-write");
        applyStimulus(1'b1, 16'h0040, 16'h0000, 2'b11, "pre_40");
        req = 1'b1; wr = 1'b1; addr = 16'h0040; data_in = 16'hCAFE; be = 2'b11;
        tick;
        req = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        lastRead = '0;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_dout", data_out, 16'h0000);
        doneCount = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            tick;
            if (done) doneCount++;
        end
        checkOutput("abort_no_done", doneCount, 0);
        applyStimulus(1'b0, 16'h0040, 16'h0000, 2'b11, "rd_40");
        checkOutput("rd_40_const", data_out, 16'h0000);

        $display("[TB] misaligned write");
        applyStimulus(1'b1, 16'h0011, 16'h7777, 2'b11, "mis_wr");
        applyStimulus(1'b0, 16'h0010, 16'h0000, 2'b11, "mis_rd");
`ifdef MC_MEM_ALIGN_CHECK_EN
        checkOutput("mis_rd_const", data_out, 16'hBEEF);
`else
        checkOutput("mis_rd_const", data_out, 16'h7777);
`endif

        $display("[TB] randomized accesses");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'h0100 + 16'(2 * i), 16'($urandom), 2'b11, "rnd_init");
        end
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'h0100 + 16'(2 * $urandom_range(0, 7)),
                          16'($urandom), 2'($urandom), "rnd");
        end

        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_mem.md
Name: mc_mem

Overview:
- Parametrised multi-cycle, byte-addressable memory with a request/busy/done handshake, fixed configurable access latency and per-byte write enables.
- Successor to the single-cycle instruction/data memories, which have combinational reads.
- Sits between the pipeline's fetch or memory stage and storage, so the stages can model stall on memory latency.
- Accepts one outstanding request at a time.

Parameters:
DATA_WIDTH, 16, word width in bits; multiple of 8, at least 16
ADDR_WIDTH, 16, byte-address width; array depth = 2**(ADDR_WIDTH-OFS) words, OFS = $clog2(DATA_WIDTH/8)
LATENCY, 4, cycles from request-accept edge to completion edge; at least 1

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-low (0 = reset)
req  input  1  request strobe
wr  input  1  1 = write, 0 = read; sampled with req
addr  input  ADDR_WIDTH  byte address; low OFS bits ignored (see Optional Feature)
data_in  input  DATA_WIDTH  write data
be  input  DATA_WIDTH/8  byte enables; be[i] covers data_in[8i+7:8i]
busy  output  1  access in progress; new requests ignored
done  output  1  one-cycle completion pulse, for reads and writes
data_out  output  DATA_WIDTH  registered read data; valid when done is high after a read
err  output  1  misaligned-access pulse; tied 0 unless macro defined

Behaviour:
- Reset (rst=0 at a rising edge):
  - State goes to IDLE; busy=0, done=0, err=0, data_out=0, latency counter=0.
  - Array contents are not cleared; uninitialised words read X in simulation.
- States are IDLE and ACCESS.
- IDLE:
  - Request accepted at edge E0 when req=1 and busy=0.
  - Edge E0 captures wr, word address addr[ADDR_WIDTH-1:OFS], data_in and be, loads the counter with LATENCY-1, and moves to ACCESS.
- ACCESS:
  - busy=1 on every cycle from E0 up to edge E0+LATENCY; busy is high for exactly LATENCY cycles.
  - Counter decrements each edge.
  - When the counter is 0 at an edge (edge E0+LATENCY), the access completes:
    - write: enabled bytes are written into the array; disabled bytes are unchanged.
    - read: the full word is registered into data_out; be is ignored.
    - done=1 for one cycle; busy=0 in the same cycle; state returns to IDLE.
- Throughput: the next request can be accepted at edge E0+LATENCY+1, i.e. on the cycle done is high. Back-to-back period is LATENCY+1 cycles.
- req while busy=1: ignored, not queued; requester must hold or re-assert req until accepted.
- Write with be all zero: completes normally with a done pulse; array unchanged.
- data_out holds the last read value until the next read completes; writes do not disturb it.
- Read accepted after a write's done returns the written data; no forwarding is required because only one access is ever outstanding.
- Reset mid-ACCESS: the pending access is aborted. No array write, no done, busy=0 the cycle after the reset edge.
- done and err are never high during reset.

Optional Feature:
- Macro: MC_MEM_ALIGN_CHECK_EN.
- Defined:
  - A request whose addr[OFS-1:0] != 0 is accepted at E0 but does not enter ACCESS.
  - The array is not accessed and data_out is unchanged.
  - err=1 and done=1 for one cycle after E0, i.e. latency 1.
  - busy stays 0.
- Undefined:
  - err is tied 0.
  - Low OFS address bits are silently ignored; the access goes to the containing word with full LATENCY.

Test Plan:
- Reset: hold rst=0 for 2 edges mid-idle, with random req -> busy=0, done=0, err=0, data_out=0x0000.
- Write then read, LATENCY=4:
  - write addr 0x0010, data 0xBEEF, be=2'b11, accepted at E0 -> busy=1 for 4 cycles, done pulse after E4.
  - read 0x0010 accepted at E5 -> done after E9 with data_out=0xBEEF, held afterwards.
- Byte enables:
  - write 0x1234 to 0x0020 (be=2'b11), then write 0xABCD with be=2'b01 -> read 0x0020 returns 0x12CD.
  - then write with be=2'b00 -> readback is still 0x12CD.
- Request while busy: during a read of 0x0010, assert a write of 0x5555 to 0x0030 on cycle 2 then drop req -> exactly one done; a later read of 0x0030 returns its prior contents.
- Reset mid-write: write 0xCAFE to 0x0040 (previously 0x0000), rst=0 at cycle 2 of ACCESS -> no done, busy=0 the next cycle, read 0x0040 returns 0x0000.
- Alignment, write 0x7777 to addr 0x0011:
  - with macro defined -> err=1 and done=1 one cycle after accept; word 0x0010 unchanged.
  - without macro -> normal 4-cycle write; word 0x0010 reads 0x7777, err stays 0.
- LATENCY=1 build: write/read pairs complete with done one cycle after accept; period is 2 cycles per access.
